// File: rtl/e_slot_alloc_if.sv
// rtl/e_slot_alloc_if.sv - allocate/free/status bundle for the round-robin slot allocator
interface e_slot_alloc_if #(
   parameter int W = 4
);
   localparam int CNT_W = $clog2(W + 1);

   logic             alloc_req_i;
   logic             alloc_gnt_o;
   logic [W-1:0]     alloc_idx_o;
   logic             free_vld_i;
   logic [W-1:0]     free_idx_i;
   logic [W-1:0]     occ_o;
   logic [CNT_W-1:0] cnt_o;
   logic             full_o;
   logic             empty_o;
   logic             err_o;

   modport master (
      output alloc_req_i, free_vld_i, free_idx_i,
      input  alloc_gnt_o, alloc_idx_o, occ_o, cnt_o, full_o, empty_o, err_o
   );

   modport slave (
      input  alloc_req_i, free_vld_i, free_idx_i,
      output alloc_gnt_o, alloc_idx_o, occ_o, cnt_o, full_o, empty_o, err_o
   );
endinterface

// File: rtl/e_slot_alloc.sv
// rtl/e_slot_alloc.sv - round-robin W-slot allocator with one-hot frees and sticky error
module e_slot_alloc #(
   parameter int W = 4
) (
   input  logic           clk,
   input  logic           arst,
   e_slot_alloc_if.slave  bus
);
   localparam int CNT_W = $clog2(W + 1);
   localparam int IW    = (W > 1) ? $clog2(W) : 1;

   generate
      if (W < 2 || W > 8) begin : g_bad_w
         $error("e_slot_alloc: W must be in 2..8");
      end
   endgenerate

   logic [W-1:0]     occ;
   logic [W-1:0]     ptr;
   logic [CNT_W-1:0] cnt;
   logic             full;
   logic             empty;
   logic             err;

   logic [W-1:0]     gnt_idx;
   logic             gnt;
   logic             free_onehot;
   logic             free_legal;
   logic             free_illegal;
   logic [W-1:0]     occ_next;
   logic [CNT_W-1:0] cnt_next;
   logic [IW-1:0]    pos;
   int               start;
   logic             found;

   // Search descends from the slot just below the last grant, wrapping 0 -> W-1.
   always_comb begin
      start   = W - 1;
      gnt_idx = '0;
      found   = 1'b0;
      pos     = '0;
      for (int i = 0; i < W; i++) begin
         if (ptr[i]) start = (i == 0) ? (W - 1) : (i - 1);
      end
      for (int j = 0; j < W; j++) begin
         pos = IW'((start + W - j) % W);
         if (!found && !occ[pos]) begin
            gnt_idx[pos] = 1'b1;
            found        = 1'b1;
         end
      end
   end

   assign gnt          = bus.alloc_req_i & ~full;
   assign free_onehot  = (bus.free_idx_i != '0) &&
                         ((bus.free_idx_i & (bus.free_idx_i - W'(1))) == '0);
   assign free_legal   = bus.free_vld_i & free_onehot & (|(bus.free_idx_i & occ));
   assign free_illegal = bus.free_vld_i & ~free_legal;

   // Grant targets a free slot and a legal free targets an occupied one, so they never collide.
   assign occ_next = (occ | (gnt ? gnt_idx : '0)) & ~(free_legal ? bus.free_idx_i : '0);
   assign cnt_next = cnt + CNT_W'(gnt) - CNT_W'(free_legal);

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         occ   <= '0;
         ptr   <= '0;
         cnt   <= '0;
         full  <= 1'b0;
         empty <= 1'b1;
         err   <= 1'b0;
      end else begin
         occ   <= occ_next;
         cnt   <= cnt_next;
         full  <= (cnt_next == CNT_W'(W));
         empty <= (cnt_next == '0);
         if (gnt)          ptr <= gnt_idx;
         if (free_illegal) err <= 1'b1;
      end
   end

   assign bus.alloc_gnt_o = gnt;
   assign bus.alloc_idx_o = gnt ? gnt_idx : '0;
   assign bus.occ_o       = occ;
   assign bus.cnt_o       = cnt;
   assign bus.full_o      = full;
   assign bus.empty_o     = empty;
   assign bus.err_o       = err;

   a_cnt_popcount: assert property (@(posedge clk) disable iff (arst)
      cnt == CNT_W'($countones(occ)));
endmodule
